// File: rtl/bin_to_thermometer_if.sv
// Input/result bundle for the binary-to-thermometer converter.
// The producer drives din/din_valid and the converter drives dout/dout_valid.
interface bin_to_thermometer_if #(
    parameter int IN_W = 8
);
    localparam int OUT_W = 2 ** IN_W;

    logic             din_valid;
    logic [IN_W-1:0]  din;
    logic             dout_valid;
    logic [OUT_W-1:0] dout;

    modport master (
        output din_valid,
        output din,
        input  dout_valid,
        input  dout
    );

    modport slave (
        input  din_valid,
        input  din,
        output dout_valid,
        output dout
    );
endinterface

// File: rtl/bin_to_thermometer.sv
// Registered N-bit binary to 2^N-bit thermometer converter: dout[i] = (i <= din).
// One clock of latency; dout holds its last value while din_valid is low.
module bin_to_thermometer #(
    parameter int IN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_thermometer_if.slave  bus
);
    localparam int OUT_W = 2 ** IN_W;

    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] dout_d;
    logic [OUT_W-1:0] dout_q;
    logic             dout_valid_d;
    logic             dout_valid_q;

    // Per-bit magnitude compare; the top index still fits in IN_W bits, so
    // din = max sets every bit with no wrap.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
        localparam logic [IN_W-1:0] IDX = IN_W'(gi);
        assign therm[gi] = (IDX <= bus.din);
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (bus.din_valid) begin
            dout_d       = therm;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_bin_to_thermometer.sv
// Bench for bin_to_thermometer: IN_W=8 and IN_W=3 instances driven in lockstep
// and compared against an arithmetic reference (2^(k+1) - 1).
module tb_bin_to_thermometer;
    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_fails  = 0;

    logic [255:0] exp8;
    logic [7:0]   exp3;
    logic         expv;

    always #5 clk = ~clk;

    bin_to_thermometer_if #(.IN_W(8)) bus8 ();
    bin_to_thermometer_if #(.IN_W(3)) bus3 ();

    bin_to_thermometer #(.IN_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    bin_to_thermometer #(.IN_W(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    function automatic logic [256:0] therm_ref(input int k);
        return (257'(1) << (k + 1)) - 257'(1);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout8"},  bus8.dout, exp8);
        chk({tag, ".valid8"}, 256'(bus8.dout_valid), 256'(expv));
        chk({tag, ".dout3"},  256'(bus3.dout), 256'(exp3));
        chk({tag, ".valid3"}, 256'(bus3.dout_valid), 256'(expv));
    endtask

    // One clock: drive at the falling edge, update the model, check after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input bit use_x, input string tag);
        logic [256:0] r8;
        logic [256:0] r3;
        @(negedge clk);
        bus8.din_valid = v;
        bus3.din_valid = v;
        bus8.din = (use_x && !v) ? 'x : d;
        bus3.din = (use_x && !v) ? 'x : d[2:0];
        if (v) begin
            r8   = therm_ref(int'(d));
            r3   = therm_ref(int'(d[2:0]));
            exp8 = r8[255:0];
            exp3 = r3[7:0];
        end
        expv = v;
        @(posedge clk);
        #1;
        chk_all(tag);
        $display("step %s valid=%0b din=%0d dout_valid=%0b popcount=%0d", tag, v, d,
                 bus8.dout_valid, $countones(bus8.dout));
    endtask

    initial begin
        rst_n          = 1'b1;
        bus8.din_valid = 1'b0;
        bus8.din       = '0;
        bus3.din_valid = 1'b0;
        bus3.din       = '0;
        exp8 = '0;
        exp3 = '0;
        expv = 1'b0;

        // Load a result, then reset asynchronously between edges.
        step(1'b1, 8'd10, 1'b0, "pre_reset");
        @(negedge clk);
        bus8.din_valid = 1'b1;
        bus3.din_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp8 = '0; exp3 = '0; expv = 1'b0;
        chk_all("reset_async");
        $display("reset asserted between edges dout_valid=%0b", bus8.dout_valid);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_all("reset_hold");
            $display("reset hold cycle %0d dout_valid=%0b", c, bus8.dout_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus8.din_valid = 1'b0;
        bus3.din_valid = 1'b0;

        // Exhaustive back-to-back sweep.
        for (int k = 0; k < 256; k++) step(1'b1, 8'(k), 1'b0, "sweep");

        step(1'b1, 8'd0, 1'b0, "din0");
        chk("din0.const", bus8.dout, 256'h1);
        step(1'b1, 8'd7, 1'b0, "din7");
        chk("din7.const", bus8.dout, 256'hFF);
        step(1'b1, 8'd255, 1'b0, "din255");
        chk("din255.const", bus8.dout, {256{1'b1}});

        step(1'b1, 8'd5, 1'b0, "w3_din5");
        chk("w3_din5.const", 256'(bus3.dout), 256'(8'b0011_1111));
        step(1'b1, 8'd7, 1'b0, "w3_din7");
        chk("w3_din7.const", 256'(bus3.dout), 256'(8'hFF));

        // Hold: invalid cycle keeps the old code.
        step(1'b1, 8'd100, 1'b0, "hold_load");
        step(1'b0, 8'd200, 1'b0, "hold");
        chk("hold.popcount", 256'($countones(bus8.dout)), 256'(101));

        // Alternating extremes with no bubbles.
        step(1'b1, 8'd255, 1'b0, "b2b_255a");
        step(1'b1, 8'd0,   1'b0, "b2b_0a");
        step(1'b1, 8'd255, 1'b0, "b2b_255b");
        step(1'b1, 8'd0,   1'b0, "b2b_0b");

        // Mid-stream reset discards the in-flight result.
        step(1'b1, 8'd50, 1'b0, "mid_50");
        step(1'b1, 8'd51, 1'b0, "mid_51");
        bus8.din_valid = 1'b1; bus8.din = 8'd52;
        bus3.din_valid = 1'b1; bus3.din = 3'(52);
        #1 rst_n = 1'b0;
        #1;
        exp8 = '0; exp3 = '0; expv = 1'b0;
        chk_all("mid_reset");
        $display("mid-stream reset dout_valid=%0b", bus8.dout_valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin
            logic [256:0] r;
            r = therm_ref(52);
            exp8 = r[255:0];
            r = therm_ref(52 % 8);
            exp3 = r[7:0];
            expv = 1'b1;
        end
        chk_all("mid_52");
        $display("after reset release din=52 popcount=%0d", $countones(bus8.dout));

        // Random traffic with X on din whenever din_valid is low.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'b1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        n_fails++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "timeout");
    end
endmodule
